// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: op codes, sizing,
// entry record and the CDB operand-capture helper.
package alu_rs_pkg;

  localparam int unsigned RS_SIZE = 8;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned OP_W    = 6;

  typedef enum logic [OP_W-1:0] {
    OP_LUI  = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL  = 6'd3,  OP_JALR  = 6'd4,
    OP_BEQ  = 6'd5,  OP_BNE   = 6'd6,  OP_BLT  = 6'd7,  OP_BGE   = 6'd8,
    OP_BLTU = 6'd9,  OP_BGEU  = 6'd10, OP_LB   = 6'd11, OP_LH    = 6'd12,
    OP_LW   = 6'd13, OP_LBU   = 6'd14, OP_LHU  = 6'd15, OP_SB    = 6'd16,
    OP_SH   = 6'd17, OP_SW    = 6'd18, OP_ADDI = 6'd19, OP_SLTI  = 6'd20,
    OP_SLTIU= 6'd21, OP_XORI  = 6'd22, OP_ORI  = 6'd23, OP_ANDI  = 6'd24,
    OP_SLLI = 6'd25, OP_SRLI  = 6'd26, OP_SRAI = 6'd27, OP_ADD   = 6'd28,
    OP_SUB  = 6'd29, OP_SLL   = 6'd30, OP_SLT  = 6'd31, OP_SLTU  = 6'd32,
    OP_XOR  = 6'd33, OP_SRL   = 6'd34, OP_SRA  = 6'd35, OP_OR    = 6'd36,
    OP_AND  = 6'd37
  } op_e;

  typedef struct packed {
    logic             busy;
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  vj;
    logic [XLEN-1:0]  vk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic             qj_pend;
    logic             qk_pend;
    logic [TAG_W-1:0] dest;
  } rs_entry_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } cdb_t;

  // Capture any pending operand whose tag is on a bus; ALU bus has priority.
  function automatic rs_entry_t cdb_wake(rs_entry_t e, cdb_t alu, cdb_t lsb);
    rs_entry_t r;
    r = e;
    if (e.qj_pend) begin
      if (alu.valid && alu.tag == e.qj) begin
        r.vj = alu.data; r.qj_pend = 1'b0;
      end else if (lsb.valid && lsb.tag == e.qj) begin
        r.vj = lsb.data; r.qj_pend = 1'b0;
      end
    end
    if (e.qk_pend) begin
      if (alu.valid && alu.tag == e.qk) begin
        r.vk = alu.data; r.qk_pend = 1'b0;
      end else if (lsb.valid && lsb.tag == e.qk) begin
        r.vk = lsb.data; r.qk_pend = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_prio_enc.sv
// Lowest-index set-bit finder: found flag plus the index of that bit.
module rs_prio_enc #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i] && !found_o) begin
        found_o = 1'b1;
        idx_o   = W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers issued ops, snoops both result buses and
// dispatches the lowest-index ready entry to the ALU each cycle.
module alu_rs
  import alu_rs_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rob_clear,
  input  logic             issue_valid,
  input  logic [OP_W-1:0]  issue_op_type,
  input  logic [XLEN-1:0]  issue_vj,
  input  logic [XLEN-1:0]  issue_vk,
  input  logic             issue_qj_pend,
  input  logic             issue_qk_pend,
  input  logic [TAG_W-1:0] issue_qj,
  input  logic [TAG_W-1:0] issue_qk,
  input  logic [TAG_W-1:0] issue_dest,
  output logic             rs_full,
  input  logic             alu_cdb_valid,
  input  logic [TAG_W-1:0] alu_cdb_tag,
  input  logic [XLEN-1:0]  alu_cdb_data,
  input  logic             lsb_cdb_valid,
  input  logic [TAG_W-1:0] lsb_cdb_tag,
  input  logic [XLEN-1:0]  lsb_cdb_data,
  output logic             alu_mission,
  output logic [OP_W-1:0]  alu_op_type,
  output logic [XLEN-1:0]  alu_rs1,
  output logic [XLEN-1:0]  alu_rs2,
  output logic [TAG_W-1:0] alu_rob_dest
);

  localparam int unsigned IDX_W = $clog2(RS_SIZE);

  rs_entry_t ent_q [RS_SIZE];
  rs_entry_t ent_d [RS_SIZE];
  rs_entry_t new_ent;

  logic             mission_q;
  logic [OP_W-1:0]  op_q;
  logic [XLEN-1:0]  rs1_q, rs2_q;
  logic [TAG_W-1:0] dest_q;

  logic [RS_SIZE-1:0] busy_vec, ready_vec;
  logic               free_found, disp_found;
  logic [IDX_W-1:0]   free_idx, disp_idx;
  cdb_t               alu_cdb, lsb_cdb;

  assign alu_cdb = '{valid: alu_cdb_valid, tag: alu_cdb_tag, data: alu_cdb_data};
  assign lsb_cdb = '{valid: lsb_cdb_valid, tag: lsb_cdb_tag, data: lsb_cdb_data};

  always_comb begin
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      busy_vec[i]  = ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy && !ent_q[i].qj_pend && !ent_q[i].qk_pend;
    end
  end

  assign rs_full = &busy_vec;

  rs_prio_enc #(.N(RS_SIZE)) u_free_sel (
    .req_i   (~busy_vec),
    .found_o (free_found),
    .idx_o   (free_idx)
  );

  rs_prio_enc #(.N(RS_SIZE)) u_disp_sel (
    .req_i   (ready_vec),
    .found_o (disp_found),
    .idx_o   (disp_idx)
  );

  always_comb begin
    new_ent = cdb_wake('{busy: 1'b1, op: issue_op_type, vj: issue_vj, vk: issue_vk,
                         qj: issue_qj, qk: issue_qk, qj_pend: issue_qj_pend,
                         qk_pend: issue_qk_pend, dest: issue_dest},
                       alu_cdb, lsb_cdb);
  end

  // Free and dispatch slots both come from pre-edge state, so they never collide.
  always_comb begin
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i].busy ? cdb_wake(ent_q[i], alu_cdb, lsb_cdb) : ent_q[i];
    end
    if (disp_found) ent_d[disp_idx].busy = 1'b0;
    if (issue_valid && free_found) ent_d[free_idx] = new_ent;
    if (rob_clear) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q     <= '{default: '0};
      mission_q <= 1'b0;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      dest_q    <= '0;
    end else begin
      mission_q <= 1'b0;
      if (rdy) begin
        ent_q <= ent_d;
        if (!rob_clear && disp_found) begin
          mission_q <= 1'b1;
          op_q      <= ent_q[disp_idx].op;
          rs1_q     <= ent_q[disp_idx].vj;
          rs2_q     <= ent_q[disp_idx].vk;
          dest_q    <= ent_q[disp_idx].dest;
        end
      end
    end
  end

  assign alu_mission  = mission_q;
  assign alu_op_type  = op_q;
  assign alu_rs1      = rs1_q;
  assign alu_rs2      = rs2_q;
  assign alu_rob_dest = dest_q;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed table, corner sequences and a
// randomized run against a slot-list reference model.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy, rob_clear, issue_valid;
  logic [5:0]  issue_op_type;
  logic [31:0] issue_vj, issue_vk;
  logic        issue_qj_pend, issue_qk_pend;
  logic [3:0]  issue_qj, issue_qk, issue_dest;
  logic        rs_full;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_tag, lsb_cdb_tag;
  logic [31:0] alu_cdb_data, lsb_cdb_data;
  logic        alu_mission;
  logic [5:0]  alu_op_type;
  logic [31:0] alu_rs1, alu_rs2;
  logic [3:0]  alu_rob_dest;

  alu_rs dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear),
    .issue_valid(issue_valid), .issue_op_type(issue_op_type),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_pend(issue_qj_pend), .issue_qk_pend(issue_qk_pend),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_dest(issue_dest),
    .rs_full(rs_full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_data(alu_cdb_data),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_data(lsb_cdb_data),
    .alu_mission(alu_mission), .alu_op_type(alu_op_type),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rob_dest(alu_rob_dest)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  string phase = "init";

  // Reference model: eight slots held as plain arrays.
  bit          m_busy [8];
  bit          m_pj [8], m_pk [8];
  logic [5:0]  m_op [8];
  logic [31:0] m_vj [8], m_vk [8];
  logic [3:0]  m_qj [8], m_qk [8], m_dest [8];
  bit          exp_mis;
  logic [5:0]  exp_op;
  logic [31:0] exp_rs1, exp_rs2;
  logic [3:0]  exp_dest;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s/%s: got %h expected %h", phase, name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_busy[i] = 0; m_pj[i] = 0; m_pk[i] = 0;
    end
    exp_mis = 0; exp_op = '0; exp_rs1 = '0; exp_rs2 = '0; exp_dest = '0;
  endtask

  task automatic snoop(input bit p, input logic [3:0] t, input logic [31:0] v,
                       output bit po, output logic [31:0] vo);
    po = p; vo = v;
    if (p && alu_cdb_valid && alu_cdb_tag == t) begin po = 0; vo = alu_cdb_data; end
    else if (p && lsb_cdb_valid && lsb_cdb_tag == t) begin po = 0; vo = lsb_cdb_data; end
  endtask

  task automatic model_step();
    int d, f;
    bit np;
    logic [31:0] nv;
    d = -1; f = -1;
    if (!rdy) begin exp_mis = 0; return; end
    if (rob_clear) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 0;
      exp_mis = 0;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      if (d < 0 && m_busy[i] && !m_pj[i] && !m_pk[i]) d = i;
      if (f < 0 && !m_busy[i]) f = i;
    end
    exp_mis = (d >= 0);
    if (d >= 0) begin
      exp_op = m_op[d]; exp_rs1 = m_vj[d]; exp_rs2 = m_vk[d]; exp_dest = m_dest[d];
      m_busy[d] = 0;
    end
    for (int i = 0; i < 8; i++) begin
      if (m_busy[i]) begin
        snoop(m_pj[i], m_qj[i], m_vj[i], np, nv); m_pj[i] = np; m_vj[i] = nv;
        snoop(m_pk[i], m_qk[i], m_vk[i], np, nv); m_pk[i] = np; m_vk[i] = nv;
      end
    end
    if (issue_valid && f >= 0) begin
      m_busy[f] = 1; m_op[f] = issue_op_type; m_dest[f] = issue_dest;
      m_qj[f] = issue_qj; m_qk[f] = issue_qk;
      snoop(issue_qj_pend, issue_qj, issue_vj, np, nv); m_pj[f] = np; m_vj[f] = nv;
      snoop(issue_qk_pend, issue_qk, issue_vk, np, nv); m_pk[f] = np; m_vk[f] = nv;
    end
  endtask

  task automatic check_outputs();
    bit full;
    full = 1;
    for (int i = 0; i < 8; i++) if (!m_busy[i]) full = 0;
    chk("mission", alu_mission, exp_mis);
    chk("op", alu_op_type, exp_op);
    chk("rs1", alu_rs1, exp_rs1);
    chk("rs2", alu_rs2, exp_rs2);
    chk("dest", alu_rob_dest, exp_dest);
    chk("full", rs_full, full);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    rdy = 1; rob_clear = 0; issue_valid = 0;
    issue_op_type = '0; issue_vj = '0; issue_vk = '0;
    issue_qj_pend = 0; issue_qk_pend = 0; issue_qj = '0; issue_qk = '0; issue_dest = '0;
    alu_cdb_valid = 0; alu_cdb_tag = '0; alu_cdb_data = '0;
    lsb_cdb_valid = 0; lsb_cdb_tag = '0; lsb_cdb_data = '0;
  endtask

  task automatic iss(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                     input bit pj, input logic [3:0] qj, input bit pk, input logic [3:0] qk,
                     input logic [3:0] dest);
    issue_valid = 1; issue_op_type = op; issue_vj = vj; issue_vk = vk;
    issue_qj_pend = pj; issue_qj = qj; issue_qk_pend = pk; issue_qk = qk; issue_dest = dest;
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] vj, vk;
    bit          pj;
    logic [3:0]  qj;
    bit          lv;
    logic [3:0]  lt;
    logic [31:0] ld;
    logic [3:0]  dest;
    bit          exp_mis;
    logic [31:0] exp_rs1;
  } vec_t;

  vec_t tbl [5];

  initial begin
    tbl[0] = '{OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd3, 1'b1, 32'd5};
    tbl[1] = '{OP_SUB, 32'hDEAD_BEEF, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd7, 1'b1, 32'hDEAD_BEEF};
    tbl[2] = '{OP_ADD, 32'd0, 32'd9, 1'b1, 4'd2, 1'b1, 4'd2, 32'hFFFF_FFFE, 4'd4, 1'b1, 32'hFFFF_FFFE};
    tbl[3] = '{OP_JALR, 32'd0, 32'h40, 1'b1, 4'd6, 1'b1, 4'd6, 32'h1234, 4'd15, 1'b1, 32'h1234};
    tbl[4] = '{OP_AND, 32'd0, 32'd3, 1'b1, 4'd6, 1'b1, 4'd5, 32'h1234, 4'd8, 1'b0, 32'd0};

    idle();
    model_reset();
    phase = "reset";
    #12;
    check_outputs();
    @(negedge clk) rst = 1;

    phase = "table";
    foreach (tbl[k]) begin
      iss(tbl[k].op, tbl[k].vj, tbl[k].vk, tbl[k].pj, tbl[k].qj, 1'b0, 4'd0, tbl[k].dest);
      lsb_cdb_valid = tbl[k].lv; lsb_cdb_tag = tbl[k].lt; lsb_cdb_data = tbl[k].ld;
      tick();
      idle();
      tick();
      chk("tbl_mission", alu_mission, tbl[k].exp_mis);
      if (tbl[k].exp_mis) begin
        chk("tbl_op", alu_op_type, tbl[k].op);
        chk("tbl_rs1", alu_rs1, tbl[k].exp_rs1);
        chk("tbl_rs2", alu_rs2, tbl[k].vk);
        chk("tbl_dest", alu_rob_dest, tbl[k].dest);
      end
      tick();
      chk("tbl_pulse_end", alu_mission, 1'b0);
    end
    rob_clear = 1; tick(); idle();

    phase = "wakeup";
    iss(OP_SUB, 32'd0, 32'd2, 1'b1, 4'd9, 1'b0, 4'd0, 4'd6);
    tick(); idle();
    alu_cdb_valid = 1; alu_cdb_tag = 4'd8; alu_cdb_data = 32'h99;
    tick(); idle();
    tick();
    chk("wrong_tag_no_disp", alu_mission, 1'b0);
    alu_cdb_valid = 1; alu_cdb_tag = 4'd9; alu_cdb_data = 32'h10;
    tick(); idle();
    chk("wake_edge_no_disp", alu_mission, 1'b0);
    tick();
    chk("wake_disp", alu_mission, 1'b1);
    chk("wake_rs1", alu_rs1, 32'h10);
    tick();

    phase = "fill";
    for (int i = 0; i < 8; i++) begin
      iss(OP_XOR, 32'd0, 32'(i), 1'b1, (i == 1) ? 4'd11 : (i == 5) ? 4'd12 : 4'd13,
          1'b0, 4'd0, 4'(i));
      tick();
    end
    chk("full_set", rs_full, 1'b1);
    iss(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
    tick(); idle();
    tick();
    chk("drop_no_disp", alu_mission, 1'b0);
    chk("still_full", rs_full, 1'b1);
    alu_cdb_valid = 1; alu_cdb_tag = 4'd12; alu_cdb_data = 32'h555;
    lsb_cdb_valid = 1; lsb_cdb_tag = 4'd11; lsb_cdb_data = 32'h111;
    tick(); idle();
    tick();
    chk("first_disp_dest", alu_rob_dest, 4'd1);
    chk("first_disp_rs1", alu_rs1, 32'h111);
    chk("full_drop", rs_full, 1'b0);
    tick();
    chk("second_disp", alu_mission, 1'b1);
    chk("second_disp_dest", alu_rob_dest, 4'd5);
    tick();
    chk("fill_idle", alu_mission, 1'b0);

    phase = "clear";
    iss(OP_OR, 32'h3, 32'h4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
    tick(); idle();
    rob_clear = 1;
    tick(); idle();
    chk("clear_mission", alu_mission, 1'b0);
    chk("clear_full", rs_full, 1'b0);
    alu_cdb_valid = 1; alu_cdb_tag = 4'd13; alu_cdb_data = 32'h77;
    tick(); idle();
    tick();
    chk("clear_no_disp", alu_mission, 1'b0);

    phase = "stall";
    iss(OP_ADD, 32'h21, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    tick(); idle();
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_no_disp", alu_mission, 1'b0);
    end
    rdy = 1;
    tick();
    chk("stall_disp", alu_mission, 1'b1);
    chk("stall_dest", alu_rob_dest, 4'd9);
    tick();
    chk("stall_single", alu_mission, 1'b0);

    phase = "midreset";
    for (int i = 0; i < 3; i++) begin
      iss(OP_SLT, 32'd0, 32'd1, 1'b1, 4'd14, 1'b0, 4'd0, 4'(i + 1));
      tick();
    end
    idle();
    #2 rst = 0;
    #1 model_reset();
    check_outputs();
    @(negedge clk) rst = 1;
    alu_cdb_valid = 1; alu_cdb_tag = 4'd14; alu_cdb_data = 32'h5;
    tick(); idle();
    tick();
    chk("post_reset_no_disp", alu_mission, 1'b0);

    phase = "random";
    for (int n = 0; n < 3000; n++) begin
      rdy = ($urandom_range(0, 9) != 0);
      rob_clear = ($urandom_range(0, 59) == 0);
      issue_valid = $urandom_range(0, 1);
      issue_op_type = 6'($urandom_range(1, 37));
      issue_vj = $urandom; issue_vk = $urandom;
      issue_qj_pend = $urandom_range(0, 1); issue_qk_pend = $urandom_range(0, 1);
      issue_qj = 4'($urandom_range(0, 5)); issue_qk = 4'($urandom_range(0, 5));
      issue_dest = 4'($urandom);
      alu_cdb_valid = ($urandom_range(0, 2) == 0);
      alu_cdb_tag = 4'($urandom_range(0, 5)); alu_cdb_data = $urandom;
      lsb_cdb_tag = 4'($urandom_range(0, 5)); lsb_cdb_data = $urandom;
      lsb_cdb_valid = ($urandom_range(0, 2) == 0) && (lsb_cdb_tag != alu_cdb_tag);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
